// File: rtl/imem_loader.sv
// Byte-stream boot loader: count byte, N big-endian words written to instruction memory, CPU held until DONE.
// Optional trailing 32-bit checksum of all words when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byteValid,
  input  logic [7:0]            byteData,
  output logic                  byteReady,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memWriteAddress,
  output logic [31:0]           memWriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  holdProcessor,
  output logic                  overflowError,
  output logic                  checksumError
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, DONE} state_t;
  localparam state_t POST_DATA = CSUM;
`else
  typedef enum logic [2:0] {IDLE, COUNT, DATA, DONE} state_t;
  localparam state_t POST_DATA = DONE;
`endif

  state_t                state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [7:0]            words_q, words_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           shift_q, shift_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  ovf_q, ovf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           csum_q, csum_d;
  logic                  cerr_q, cerr_d;
`endif

  logic        xfer;
  logic [31:0] word;
  logic        in_range;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byteReady = (state_q == COUNT) || (state_q == DATA) || (state_q == CSUM);
  assign checksumError = cerr_q;
`else
  assign byteReady = (state_q == COUNT) || (state_q == DATA);
  assign checksumError = 1'b0;
`endif

  assign busy            = byteReady;
  assign done            = (state_q == DONE);
  assign holdProcessor   = (state_q != DONE);
  assign memWriteEnable  = we_q;
  assign memWriteAddress = addr_q;
  assign memWriteData    = data_q;
  assign overflowError   = ovf_q;

  assign xfer = byteValid && byteReady;
  assign word = {shift_q, byteData};
  // Word indices at or beyond the memory depth are counted but never written.
  assign in_range = ((words_q >> ADDR_WIDTH) == 8'd0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    words_d    = words_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    cerr_d     = cerr_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = COUNT;
          words_d    = 8'd0;
          byte_idx_d = 2'd0;
          ovf_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 32'd0;
          cerr_d     = 1'b0;
`endif
        end
      end
      COUNT: begin
        if (xfer) begin
          count_d = byteData;
          state_d = (byteData == 8'd0) ? POST_DATA : DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {shift_q[15:0], byteData};
          if (byte_idx_q == 2'd3) begin
            words_d = words_q + 8'd1;
            if (in_range) begin
              we_d   = 1'b1;
              addr_d = ADDR_WIDTH'(words_q);
              data_d = word;
            end else begin
              ovf_d = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q + word;
`endif
            if (words_q == count_q - 8'd1) begin
              state_d = POST_DATA;
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {shift_q[15:0], byteData};
          if (byte_idx_q == 2'd3) begin
            cerr_d  = (word != csum_q);
            state_d = DONE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 8'd0;
      words_q    <= 8'd0;
      byte_idx_q <= 2'd0;
      shift_q    <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      ovf_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 32'd0;
      cerr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      words_q    <= words_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      cerr_q     <= cerr_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (depth 32 and depth 4) share one random byte stream and are
// compared every cycle against a queue-based model of the load protocol, plus directed literal checks.
module tb_imem_loader;
  logic       clock, reset, start, byteValid;
  logic [7:0] byteData;

  logic        rdy0, we0, busy0, done0, hold0, ovf0, cerr0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic        rdy1, we1, busy1, done1, hold1, ovf1, cerr1;
  logic [1:0]  addr1;
  logic [31:0] data1;

  imem_loader #(.ADDR_WIDTH(5)) u_dut (
    .clock(clock), .reset(reset), .start(start), .byteValid(byteValid), .byteData(byteData),
    .byteReady(rdy0), .memWriteEnable(we0), .memWriteAddress(addr0), .memWriteData(data0),
    .busy(busy0), .done(done0), .holdProcessor(hold0), .overflowError(ovf0), .checksumError(cerr0));

  imem_loader #(.ADDR_WIDTH(2)) u_ovf (
    .clock(clock), .reset(reset), .start(start), .byteValid(byteValid), .byteData(byteData),
    .byteReady(rdy1), .memWriteEnable(we1), .memWriteAddress(addr1), .memWriteData(data1),
    .busy(busy1), .done(done1), .holdProcessor(hold1), .overflowError(ovf1), .checksumError(cerr1));

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  int          log_addr0[$], log_addr1[$];
  logic [31:0] log_data0[$], log_data1[$];
  logic [31:0] stream[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model phases: 0 idle, 1 count, 2 data, 3 checksum, 4 done.
  int          m_phase = 0;
  int          m_n = 0;
  int          m_words = 0;
  logic [31:0] m_sum = 0;
  logic [7:0]  m_q[$];
  logic        m_we[2];
  int          m_addr[2];
  logic [31:0] m_data[2];
  logic        m_ovf[2];
  logic        m_cerr = 1'b0;

  function automatic int depth_of(input int i);
    return (i == 0) ? 32 : 4;
  endfunction

  function automatic bit m_ready();
    return (m_phase == 1) || (m_phase == 2) || (m_phase == 3);
  endfunction

  initial begin : model
    logic [31:0] w;
    bit xfer;
    forever begin
      @(posedge clock);
      xfer = byteValid && m_ready();
      m_we[0] = 1'b0;
      m_we[1] = 1'b0;
      if (reset) begin
        m_phase = 0;
        m_q.delete();
        m_cerr = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_ovf[i] = 1'b0; m_addr[i] = 0; m_data[i] = 32'd0;
        end
      end else begin
        case (m_phase)
          0, 4: if (start) begin
            m_phase = 1; m_words = 0; m_sum = 32'd0; m_q.delete();
            m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_cerr = 1'b0;
          end
          1: if (xfer) begin
            m_n = int'(byteData);
            m_phase = (m_n == 0) ? (CS ? 3 : 4) : 2;
          end
          2: if (xfer) begin
            m_q.push_back(byteData);
            if (m_q.size() == 4) begin
              w = {m_q[0], m_q[1], m_q[2], m_q[3]};
              m_q.delete();
              m_sum = m_sum + w;
              for (int i = 0; i < 2; i++) begin
                if (m_words < depth_of(i)) begin
                  m_we[i] = 1'b1; m_addr[i] = m_words; m_data[i] = w;
                end else begin
                  m_ovf[i] = 1'b1;
                end
              end
              m_words++;
              if (m_words == m_n) m_phase = CS ? 3 : 4;
            end
          end
          3: if (xfer) begin
            m_q.push_back(byteData);
            if (m_q.size() == 4) begin
              w = {m_q[0], m_q[1], m_q[2], m_q[3]};
              m_q.delete();
              m_cerr = (w != m_sum);
              m_phase = 4;
            end
          end
          default: ;
        endcase
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clock);
      if (armed) begin
        chk("ready0", rdy0, m_ready());
        chk("busy0", busy0, m_ready());
        chk("done0", done0, m_phase == 4);
        chk("hold0", hold0, m_phase != 4);
        chk("we0", we0, m_we[0]);
        chk("addr0", addr0, m_addr[0]);
        chk("data0", data0, m_data[0]);
        chk("ovf0", ovf0, m_ovf[0]);
        chk("cerr0", cerr0, CS ? m_cerr : 1'b0);
        chk("ready1", rdy1, m_ready());
        chk("done1", done1, m_phase == 4);
        chk("hold1", hold1, m_phase != 4);
        chk("we1", we1, m_we[1]);
        chk("addr1", addr1, m_addr[1]);
        chk("data1", data1, m_data[1]);
        chk("ovf1", ovf1, m_ovf[1]);
        chk("cerr1", cerr1, CS ? m_cerr : 1'b0);
        if (we0) begin log_addr0.push_back(int'(addr0)); log_data0.push_back(data0); end
        if (we1) begin log_addr1.push_back(int'(addr1)); log_data1.push_back(data1); end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_logs();
    log_addr0.delete(); log_data0.delete(); log_addr1.delete(); log_data1.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int g;
    g = 0;
    byteValid = 1'b1;
    byteData  = b;
    while (!rdy0 && g < 40) begin
      tick();
      g++;
    end
    chk("byteReady_wait", rdy0, 1'b1);
    tick();
    byteValid = 1'b0;
    byteData  = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) send(w[8*k +: 8], gap);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!done0 && g < 20) begin
      tick();
      g++;
    end
    chk("done_wait", done0, 1'b1);
  endtask

  task automatic load_stream(input int gap, input bit bad_csum);
    logic [31:0] s;
    s = 32'd0;
    send(8'(stream.size()), gap);
    foreach (stream[i]) begin
      send_word(stream[i], gap);
      s = s + stream[i];
    end
    if (CS) send_word(bad_csum ? 32'd0 : s, gap);
  endtask

  task automatic check_basic_log(input string tag);
    chk({tag, "_nwrites"}, log_addr0.size(), 2);
    if (log_addr0.size() == 2) begin
      chk({tag, "_a0"}, log_addr0[0], 0);
      chk({tag, "_d0"}, log_data0[0], 32'h12345678);
      chk({tag, "_a1"}, log_addr0[1], 1);
      chk({tag, "_d1"}, log_data0[1], 32'hAABBCCDD);
    end
  endtask

  initial begin : global_timeout
    #600000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] s;
    int n, gap, rst_at;
    bit do_rst, aborted;
    reset = 1'b1; start = 1'b0; byteValid = 1'b0; byteData = 8'd0;
    tick();
    tick();
    armed = 1'b1;
    chk("rst_hold", hold0, 1'b1);
    chk("rst_ready", rdy0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_we", we0, 1'b0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 32'd0);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_cerr", cerr0, 1'b0);
    reset = 1'b0;
    tick();

    // Basic two-word load, write strobe one cycle after each 4th byte.
    clear_logs();
    pulse_start();
    send(8'h02, 0);
    send_word(32'h12345678, 0);
    chk("w0_strobe", we0, 1'b1);
    chk("w0_addr", addr0, 0);
    chk("w0_data", data0, 32'h12345678);
    send_word(32'hAABBCCDD, 0);
    chk("w1_strobe", we0, 1'b1);
    chk("w1_addr", addr0, 1);
    chk("w1_data", data0, 32'hAABBCCDD);
    if (CS) send_word(32'hBCF02355, 0);
    wait_done();
    chk("basic_hold", hold0, 1'b0);
    chk("basic_cerr", cerr0, 1'b0);
    tick();
    check_basic_log("basic");

    // Zero-length load.
    clear_logs();
    pulse_start();
    send(8'h00, 0);
    if (CS) send_word(32'd0, 0);
    chk("n0_done", done0, 1'b1);
    tick();
    tick();
    chk("n0_nwrites", log_addr0.size(), 0);

    // Overflow on the depth-4 instance.
    clear_logs();
    stream.delete();
    for (int k = 0; k < 5; k++) stream.push_back(32'hC0DE0000 | k);
    pulse_start();
    load_stream(0, 1'b0);
    wait_done();
    tick();
    chk("ovf_nwrites1", log_addr1.size(), 4);
    for (int k = 0; k < 4 && k < log_addr1.size(); k++) begin
      chk("ovf_addr1", log_addr1[k], k);
      chk("ovf_data1", log_data1[k], 32'hC0DE0000 | k);
    end
    chk("ovf_flag1", ovf1, 1'b1);
    chk("ovf_done1", done1, 1'b1);
    chk("ovf_nwrites0", log_addr0.size(), 5);
    chk("ovf_flag0", ovf0, 1'b0);

    // Toggled valid with a start pulse mid-DATA.
    clear_logs();
    pulse_start();
    send(8'h02, 1);
    send(8'h12, 1);
    send(8'h34, 1);
    pulse_start();
    send(8'h56, 1);
    send(8'h78, 1);
    send_word(32'hAABBCCDD, 1);
    if (CS) send_word(32'hBCF02355, 1);
    wait_done();
    tick();
    check_basic_log("toggle");
    chk("toggle_ovf_cleared1", ovf1, 1'b0);

    // Reset mid-word, then a fresh load from address 0.
    clear_logs();
    pulse_start();
    send(8'h02, 0);
    send_word(32'h12345678, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    do_reset();
    chk("midrst_we", we0, 1'b0);
    chk("midrst_hold", hold0, 1'b1);
    chk("midrst_busy", busy0, 1'b0);
    tick();
    chk("midrst_nwrites", log_addr0.size(), 1);
    clear_logs();
    stream.delete();
    stream.push_back(32'h12345678);
    stream.push_back(32'hAABBCCDD);
    pulse_start();
    load_stream(0, 1'b0);
    wait_done();
    tick();
    check_basic_log("fresh");

    if (CS) begin
      pulse_start();
      load_stream(0, 1'b1);
      wait_done();
      chk("csum_bad", cerr0, 1'b1);
      pulse_start();
      load_stream(0, 1'b0);
      wait_done();
      chk("csum_good", cerr0, 1'b0);
    end

    // Randomized loads with gaps, ignored start pulses and occasional mid-load resets.
    for (int l = 0; l < 30; l++) begin
      n = $urandom_range(0, 7);
      gap = $urandom_range(0, 2);
      do_rst = ($urandom_range(0, 7) == 0);
      rst_at = $urandom_range(0, 4 * n);
      aborted = 1'b0;
      stream.delete();
      for (int k = 0; k < n; k++) stream.push_back($urandom);
      repeat ($urandom_range(0, 2)) tick();
      pulse_start();
      send(8'(n), gap);
      s = 32'd0;
      for (int i = 0; i < 4 * n && !aborted; i++) begin
        if (do_rst && i == rst_at) begin
          do_reset();
          aborted = 1'b1;
        end else begin
          if ($urandom_range(0, 9) == 0) pulse_start();
          send(stream[i / 4][8 * (3 - i % 4) +: 8], $urandom_range(0, 2));
          if (i % 4 == 3) s = s + stream[i / 4];
        end
      end
      if (!aborted) begin
        if (CS) send_word(($urandom_range(0, 1) == 0) ? s : 32'($urandom), gap);
        wait_done();
      end
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
